// File: rtl/colocador_barcos_pc.sv
// colocador_barcos_pc: places the computer's NUM_BARCOS ships (lengths NUM_BARCOS..1)
// on an N x N board from random row/column/orientation candidates. Every attempt is
// bounds- and overlap-checked one cell per cycle and retried up to MAX_INTENTOS times.
// Accepted ships are written one cell per cycle to the game board and the bitmap.
// Optional feature: define SEPARACION_BARCOS_EN to keep ships from touching (halo map).
module colocador_barcos_pc #(
    parameter int N            = 5,
    parameter int NUM_BARCOS   = 5,
    parameter int COORD_W      = 4,
    parameter int MAX_INTENTOS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [COORD_W-1:0] fila_rnd,
    input  logic [COORD_W-1:0] col_rnd,
    input  logic               orient_rnd,
    output logic               ocupado,
    output logic               barcos_colocados,
    output logic               fallo,
    output logic               celda_wr,
    output logic [COORD_W-1:0] celda_fila,
    output logic [COORD_W-1:0] celda_col,
    output logic [2:0]         celda_id,
    output logic [N*N-1:0]     tablero_ocup
);
    localparam int CW1   = COORD_W + 1;
    localparam int IDX_W = (N * N > 1) ? $clog2(N * N) : 1;
    localparam int BW    = $clog2(NUM_BARCOS + 1);
    localparam int IW    = $clog2(MAX_INTENTOS + 1);
    localparam logic [CW1-1:0] N_C   = CW1'(N);
    localparam logic [CW1-1:0] NB_C  = CW1'(NUM_BARCOS);
    localparam logic [BW-1:0]  NB_B  = BW'(NUM_BARCOS);
    localparam logic [IW-1:0]  MAX_I = IW'(MAX_INTENTOS);

    typedef enum logic [2:0] {
        IDLE, CARGAR, VERIFICAR, ESCRIBIR, HECHO, FALLO
    } estado_t;

    estado_t        state_q, state_d;
    logic [CW1-1:0] fila_q, fila_d, col_q, col_d;
    logic           orient_q, orient_d;
    logic [CW1-1:0] len_q, len_d, k_q, k_d;
    logic [BW-1:0]  barco_q, barco_d;
    logic [IW-1:0]  intentos_q, intentos_d;
    logic [N*N-1:0] tablero_q, tablero_d;
`ifdef SEPARACION_BARCOS_EN
    logic [N*N-1:0] halo_q, halo_d;
`endif

    // Coordinates, flat index and legality of the current cell k of the candidate.
    logic [CW1-1:0]   fila_k, col_k, inicio_eje;
    logic [IDX_W-1:0] idx;
    logic [N*N-1:0]   ocup_ref;
    logic             fuera, bloqueada;

    assign tablero_ocup = tablero_q;

    // Candidate geometry: cell k, bounds test on the growth axis, blocking map lookup.
    always_comb begin
        fila_k     = orient_q ? fila_q + k_q : fila_q;
        col_k      = orient_q ? col_q : col_q + k_q;
        inicio_eje = orient_q ? fila_q : col_q;
        idx        = IDX_W'(fila_k) * IDX_W'(N) + IDX_W'(col_k);
        fuera      = (fila_q >= N_C) || (col_q >= N_C) ||
                     (inicio_eje + len_q - CW1'(1) >= N_C);
`ifdef SEPARACION_BARCOS_EN
        ocup_ref   = halo_q;
`else
        ocup_ref   = tablero_q;
`endif
        bloqueada  = !fuera && ocup_ref[idx];
    end

    // Next-state and output logic of the placement FSM.
    always_comb begin
        state_d          = state_q;
        fila_d           = fila_q;
        col_d            = col_q;
        orient_d         = orient_q;
        len_d            = len_q;
        k_d              = k_q;
        barco_d          = barco_q;
        intentos_d       = intentos_q;
        tablero_d        = tablero_q;
`ifdef SEPARACION_BARCOS_EN
        halo_d           = halo_q;
`endif
        ocupado          = 1'b0;
        barcos_colocados = 1'b0;
        fallo            = 1'b0;
        celda_wr         = 1'b0;
        celda_fila       = '0;
        celda_col        = '0;
        celda_id         = '0;
        case (state_q)
            IDLE, HECHO, FALLO: begin
                barcos_colocados = (state_q == HECHO);
                fallo            = (state_q == FALLO);
                if (iniciar) begin
                    tablero_d  = '0;
`ifdef SEPARACION_BARCOS_EN
                    halo_d     = '0;
`endif
                    barco_d    = '0;
                    intentos_d = '0;
                    k_d        = '0;
                    state_d    = CARGAR;
                end
            end
            CARGAR: begin
                ocupado  = 1'b1;
                fila_d   = {1'b0, fila_rnd};
                col_d    = {1'b0, col_rnd};
                orient_d = orient_rnd;
                len_d    = NB_C - CW1'(barco_q);
                k_d      = '0;
                state_d  = VERIFICAR;
            end
            VERIFICAR: begin
                ocupado = 1'b1;
                if (fuera || bloqueada) begin
                    intentos_d = intentos_q + IW'(1);
                    k_d        = '0;
                    state_d    = (intentos_q + IW'(1) == MAX_I) ? FALLO : CARGAR;
                end else if (k_q == len_q - CW1'(1)) begin
                    k_d     = '0;
                    state_d = ESCRIBIR;
                end else begin
                    k_d = k_q + CW1'(1);
                end
            end
            ESCRIBIR: begin
                ocupado        = 1'b1;
                celda_wr       = 1'b1;
                celda_fila     = fila_k[COORD_W-1:0];
                celda_col      = col_k[COORD_W-1:0];
                celda_id       = 3'(len_q);
                tablero_d[idx] = 1'b1;
`ifdef SEPARACION_BARCOS_EN
                // Mark the written cell and its 8 neighbours, clipped at the edges.
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        if (r >= int'(fila_k) - 1 && r <= int'(fila_k) + 1 &&
                            c >= int'(col_k) - 1 && c <= int'(col_k) + 1) begin
                            halo_d[r*N+c] = 1'b1;
                        end
                    end
                end
`endif
                if (k_q == len_q - CW1'(1)) begin
                    k_d        = '0;
                    intentos_d = '0;
                    barco_d    = barco_q + BW'(1);
                    state_d    = (barco_q + BW'(1) == NB_B) ? HECHO : CARGAR;
                end else begin
                    k_d = k_q + CW1'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fila_q     <= '0;
            col_q      <= '0;
            orient_q   <= 1'b0;
            len_q      <= '0;
            k_q        <= '0;
            barco_q    <= '0;
            intentos_q <= '0;
            tablero_q  <= '0;
`ifdef SEPARACION_BARCOS_EN
            halo_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fila_q     <= fila_d;
            col_q      <= col_d;
            orient_q   <= orient_d;
            len_q      <= len_d;
            k_q        <= k_d;
            barco_q    <= barco_d;
            intentos_q <= intentos_d;
            tablero_q  <= tablero_d;
`ifdef SEPARACION_BARCOS_EN
            halo_q     <= halo_d;
`endif
        end
    end
endmodule

// File: tb/tb_colocador_barcos_pc.sv
// Bench for colocador_barcos_pc: directed and random placement games compared cycle by
// cycle with a board-level reference model. Build with SEPARACION_BARCOS_EN for the halo.
`timescale 1ns/1ps
module tb_colocador_barcos_pc;
`ifdef SEPARACION_BARCOS_EN
    localparam int N = 8;
`else
    localparam int N = 5;
`endif
    localparam int NB   = 5;
    localparam int CW   = 4;
    localparam int MAXI = 4;
    localparam int NN   = N * N;

    logic          clk = 1'b0;
    logic          reset, iniciar, orient_rnd;
    logic [CW-1:0] fila_rnd, col_rnd;
    logic          ocupado, barcos_colocados, fallo, celda_wr;
    logic [CW-1:0] celda_fila, celda_col;
    logic [2:0]    celda_id;
    logic [NN-1:0] tablero_ocup;

    colocador_barcos_pc #(.N(N), .NUM_BARCOS(NB), .COORD_W(CW), .MAX_INTENTOS(MAXI)) dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .fila_rnd(fila_rnd), .col_rnd(col_rnd),
        .orient_rnd(orient_rnd), .ocupado(ocupado), .barcos_colocados(barcos_colocados),
        .fallo(fallo), .celda_wr(celda_wr), .celda_fila(celda_fila), .celda_col(celda_col),
        .celda_id(celda_id), .tablero_ocup(tablero_ocup)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          ocup;
        logic          wr;
        logic [CW-1:0] f;
        logic [CW-1:0] c;
        logic [2:0]    id;
        logic          done;
        logic          fail;
        logic [NN-1:0] map;
    } rec_t;

    typedef struct packed {
        logic [CW-1:0] f;
        logic [CW-1:0] c;
        logic          o;
    } att_t;

    rec_t exp_q[$];
    att_t dir_q[$];
    bit   occ[N][N];
    bit   halo[N][N];
    int   ship, tries;
    bit   running;
    rec_t final_rec;
    int   checks = 0;
    int   errors = 0;
    int   wr_count, id4_count, done_edge;

    function automatic logic [NN-1:0] cur_map();
        logic [NN-1:0] m;
        m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (occ[r][c]) m[r*N+c] = 1'b1;
        return m;
    endfunction

    function automatic bit blocked(int r, int c);
`ifdef SEPARACION_BARCOS_EN
        return halo[r][c];
`else
        return occ[r][c];
`endif
    endfunction

    // One attempt at board level: expected cycle records for load, checks and writes.
    function automatic void model_attempt(int f, int c, int o);
        int   len, v, r, cc;
        bit   ok;
        rec_t b, w;
        len    = NB - ship;
        b      = '0;
        b.ocup = 1'b1;
        b.map  = cur_map();
        exp_q.push_back(b);
        ok = 1'b1;
        v  = len;
        if (f >= N || c >= N || (o != 0 ? f : c) + len - 1 >= N) begin
            ok = 1'b0;
            v  = 1;
        end else begin
            for (int k = 0; k < len; k++) begin
                r  = (o != 0) ? f + k : f;
                cc = (o != 0) ? c : c + k;
                if (blocked(r, cc)) begin
                    ok = 1'b0;
                    v  = k + 1;
                    break;
                end
            end
        end
        for (int i = 0; i < v; i++) exp_q.push_back(b);
        if (ok) begin
            for (int k = 0; k < len; k++) begin
                r     = (o != 0) ? f + k : f;
                cc    = (o != 0) ? c : c + k;
                w     = b;
                w.wr  = 1'b1;
                w.f   = CW'(r);
                w.c   = CW'(cc);
                w.id  = 3'(len);
                w.map = cur_map();
                exp_q.push_back(w);
                occ[r][cc] = 1'b1;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (r + dr >= 0 && r + dr < N && cc + dc >= 0 && cc + dc < N)
                            halo[r+dr][cc+dc] = 1'b1;
            end
            ship++;
            tries = 0;
            if (ship == NB) begin
                running        = 1'b0;
                final_rec      = '0;
                final_rec.done = 1'b1;
                final_rec.map  = cur_map();
            end
        end else begin
            tries++;
            if (tries == MAXI) begin
                running        = 1'b0;
                final_rec      = '0;
                final_rec.fail = 1'b1;
                final_rec.map  = cur_map();
            end
        end
    endfunction

    task automatic check_rec(input string tag, input rec_t e, input bit mask_coords);
        rec_t o;
        o = {ocupado, celda_wr, celda_fila, celda_col, celda_id, barcos_colocados, fallo,
             tablero_ocup};
        if (mask_coords && !e.wr) begin
            o.f  = '0;
            o.c  = '0;
            o.id = '0;
        end
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive_junk();
        fila_rnd   = CW'($urandom);
        col_rnd    = CW'($urandom);
        orient_rnd = 1'($urandom);
    endtask

    function automatic att_t rnd_att();
        att_t a;
        a.f = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 15)) : CW'($urandom_range(0, N - 1));
        a.c = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 15)) : CW'($urandom_range(0, N - 1));
        a.o = 1'($urandom);
        return a;
    endfunction

    function automatic att_t at(int f, int c, int o);
        att_t a;
        a.f = CW'(f);
        a.c = CW'(c);
        a.o = 1'(o);
        return a;
    endfunction

    // Start a game with iniciar, then compare every cycle against the model.
    task automatic play_game(input string tag, input int reset_cyc);
        rec_t e;
        att_t a;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                occ[r][c]  = 1'b0;
                halo[r][c] = 1'b0;
            end
        ship      = 0;
        tries     = 0;
        running   = 1'b1;
        final_rec = '0;
        exp_q.delete();
        wr_count  = 0;
        id4_count = 0;
        done_edge = 0;
        @(negedge clk);
        iniciar = 1'b1;
        drive_junk();
        @(negedge clk);
        iniciar = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (running && exp_q.size() == 0) begin
                a = (dir_q.size() > 0) ? dir_q.pop_front() : rnd_att();
                fila_rnd   = a.f;
                col_rnd    = a.c;
                orient_rnd = a.o;
                model_attempt(int'(a.f), int'(a.c), int'(a.o));
            end else begin
                drive_junk();
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : final_rec;
            iniciar = e.ocup && ($urandom_range(0, 7) == 0);
            check_rec(tag, e, 1'b1);
            if (celda_wr) wr_count++;
            if (celda_wr && celda_id == 3'd4) id4_count++;
            if (barcos_colocados && done_edge == 0) done_edge = cyc - 1;
            if (cyc == reset_cyc) begin
                reset   = 1'b0;
                iniciar = 1'b0;
                #1;
                check_rec("reset_mid_write", '0, 1'b0);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (!running && exp_q.size() == 0 && !e.ocup) begin
                iniciar = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check_int({tag, "_budget"}, 1, 0);
    endtask

    function automatic logic [NN-1:0] staircase_map();
        logic [NN-1:0] m;
        m = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c <= 4 - r; c++) m[r*N+c] = 1'b1;
        return m;
    endfunction

    task automatic load_staircase();
        dir_q.delete();
        for (int r = 0; r < 5; r++) dir_q.push_back(at(r, 0, 0));
    endtask

    initial begin
        reset      = 1'b0;
        iniciar    = 1'b0;
        fila_rnd   = '0;
        col_rnd    = '0;
        orient_rnd = 1'b0;
        repeat (3) @(negedge clk);
        check_rec("reset_state", '0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_rec("idle_after_reset", '0, 1'b0);

`ifndef SEPARACION_BARCOS_EN
        load_staircase();
        play_game("scn1", 0);
        check_int("scn1_done_edge", done_edge, 35);
        check_int("scn1_writes", wr_count, 15);
        check_int("scn1_map", int'(tablero_ocup === staircase_map()), 1);

        dir_q.delete();
        dir_q.push_back(at(0, 1, 0));
        for (int r = 0; r < 5; r++) dir_q.push_back(at(r, 0, 0));
        play_game("scn2", 0);
        check_int("scn2_done_edge", done_edge, 37);

        dir_q.delete();
        dir_q.push_back(at(0, 0, 0));
        dir_q.push_back(at(0, 2, 1));
        for (int r = 1; r < 5; r++) dir_q.push_back(at(r, 0, 0));
        play_game("scn3", 0);
        check_int("scn3_done_edge", done_edge, 37);
        check_int("scn3_id4_writes", id4_count, 4);

        dir_q.delete();
        for (int i = 0; i < MAXI; i++) dir_q.push_back(at(3, 3, 0));
        play_game("scn4", 0);
        check_int("scn4_fallo", int'(fallo), 1);
        check_int("scn4_ocupado", int'(ocupado), 0);
        check_int("scn4_map_empty", int'(tablero_ocup === '0), 1);
        load_staircase();
        play_game("scn4_restart", 0);
        check_int("scn4_restart_done", done_edge, 35);

        load_staircase();
        play_game("scn5_pre", 18);
        load_staircase();
        play_game("scn5_post", 0);
        check_int("scn5_done_edge", done_edge, 35);
        check_int("scn5_writes", wr_count, 15);
`else
        dir_q.delete();
        dir_q.push_back(at(0, 0, 0));
        dir_q.push_back(at(1, 0, 0));
        dir_q.push_back(at(2, 0, 0));
        dir_q.push_back(at(4, 0, 0));
        dir_q.push_back(at(6, 0, 0));
        dir_q.push_back(at(0, 7, 0));
        play_game("scn6", 0);
        check_int("scn6_done_edge", done_edge, 37);
        check_int("scn6_row1_empty", int'(tablero_ocup[2*N-1:N] === '0), 1);
`endif

        dir_q.delete();
        for (int g = 0; g < 8; g++) play_game("random_game", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
